// File: rtl/mips_dbg_pkg.sv
// Shared debug definitions for the MIPS core.
// Command codes, sequencer states and soft-reset defaults.
package mips_dbg_pkg;

  typedef enum logic [1:0] {
    CMD_RUN  = 2'b00,
    CMD_STEP = 2'b01,
    CMD_STOP = 2'b10,
    CMD_CLR  = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_STEP = 3'd2,
    ST_DONE = 3'd3,
    ST_SRST = 3'd4
  } state_e;

  localparam int RST_CYCLES_DEF = 4;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with enable, sync clear and saturation.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Clear wins over counting; stop at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q_o = cnt_q;

endmodule

// File: rtl/exec_step_ctrl.sv
// Execution sequencer: run/step/stop/clear control,
// breakpoint pause, halt detect and stepped-cycle count.
module exec_step_ctrl
  import mips_dbg_pkg::*;
#(
  parameter int NBITS      = 32,
  parameter int CNT_BITS   = 32,
  parameter int RST_CYCLES = RST_CYCLES_DEF
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_cmd_valid,
  input  logic [1:0]          i_cmd,
  output logic                o_cmd_ready,
  input  logic                i_halt_wb,
  input  logic [NBITS-1:0]    i_pc,
  input  logic                i_bp_en,
  input  logic [NBITS-1:0]    i_bp_addr,
  output logic                o_step,
  output logic                o_cpu_reset,
  output logic                o_step_done,
  output logic                o_halted,
  output logic                o_bp_hit,
  output logic [2:0]          o_state,
  output logic [CNT_BITS-1:0] o_cycle_count
);

  localparam int RCW =
    (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCW-1:0] RST_LAST =
    RCW'(RST_CYCLES - 1);

  state_e         state_q;
  state_e         state_d;
  logic [RCW-1:0] rst_cnt_q;
  logic [RCW-1:0] rst_cnt_d;
  logic           cpu_rst_q;
  logic           step_done_q;
  logic           halted_q;
  logic           bp_hit_q;

  cmd_e           cmd;
  logic           take;
  logic           bp_match;
  logic           bp_stop;
  logic           srst_entry;

  assign cmd      = cmd_e'(i_cmd);
  assign take     = i_cmd_valid & o_cmd_ready;
  assign bp_match = i_bp_en & (i_pc == i_bp_addr);

  // Handshake readiness and pipeline advance enable.
  always_comb begin
    o_cmd_ready = 1'b0;
    o_step      = 1'b0;
    case (state_q)
      ST_IDLE: o_cmd_ready = 1'b1;
      ST_RUN: begin
        o_cmd_ready = 1'b1;
        o_step      = !bp_match | i_halt_wb;
      end
      ST_STEP: o_step      = 1'b1;
      ST_DONE: o_cmd_ready = 1'b1;
      default: ;
    endcase
  end

  // Next-state selection, highest priority first.
  always_comb begin
    state_d = state_q;
    bp_stop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (take) begin
          case (cmd)
            CMD_RUN:  state_d = ST_RUN;
            CMD_STEP: state_d = ST_STEP;
            CMD_CLR:  state_d = ST_SRST;
            default:  ;
          endcase
        end
      end
      ST_RUN: begin
        if (take && cmd == CMD_CLR) begin
          state_d = ST_SRST;
        end else if (i_halt_wb) begin
          state_d = ST_DONE;
        end else if (take && cmd == CMD_STOP) begin
          state_d = ST_IDLE;
        end else if (bp_match) begin
          state_d = ST_IDLE;
          bp_stop = 1'b1;
        end
      end
      ST_STEP: begin
        state_d = i_halt_wb ? ST_DONE : ST_IDLE;
      end
      ST_DONE: begin
        if (take && cmd == CMD_CLR) begin
          state_d = ST_SRST;
        end
      end
      ST_SRST: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign srst_entry =
    (state_d == ST_SRST) && (state_q != ST_SRST);

  // Soft-reset length counter, restarted on entry.
  always_comb begin
    rst_cnt_d = rst_cnt_q;
    if (srst_entry) begin
      rst_cnt_d = '0;
    end else if (state_q == ST_SRST) begin
      rst_cnt_d = (rst_cnt_q == RST_LAST) ?
                  '0 : rst_cnt_q + RCW'(1);
    end
  end

  // State register and registered status outputs.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= ST_IDLE;
      rst_cnt_q   <= '0;
      cpu_rst_q   <= 1'b0;
      step_done_q <= 1'b0;
      halted_q    <= 1'b0;
      bp_hit_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      cpu_rst_q   <= (state_d == ST_SRST);
      step_done_q <= (state_q == ST_STEP);
      halted_q    <= (state_d == ST_DONE);
      bp_hit_q    <= bp_stop;
    end
  end

  sat_counter #(
    .W(CNT_BITS)
  ) u_cycle_cnt (
    .clk_i  (i_clk),
    .rst_ni (i_reset),
    .en_i   (o_step),
    .clr_i  (srst_entry),
    .q_o    (o_cycle_count)
  );

  assign o_cpu_reset = cpu_rst_q;
  assign o_step_done = step_done_q;
  assign o_halted    = halted_q;
  assign o_bp_hit    = bp_hit_q;
  assign o_state     = state_q;

endmodule

// File: doc/exec_step_ctrl.md
Name: exec_step_ctrl

Overview:
- Execution sequencer for the MIPS core.
- Generates the global step enable (o_step) consumed by PC and pipeline registers, and the soft CPU reset (o_cpu_reset).
- Driven by debug-unit commands over a valid/ready handshake: RUN, STEP, STOP, CLR.
- Stops on HALT writeback or on a PC breakpoint, and counts stepped cycles for the debug unit.

Parameters:
- NBITS, 32, PC/address width.
- CNT_BITS, 32, width of the stepped-cycle counter.
- RST_CYCLES, 4, length of the soft-reset pulse in clocks (>=1).

Ports:
- i_clk  in  1  system clock; all state updates on rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_cmd_valid  in  1  command present.
- i_cmd  in  2  command code: 00 RUN, 01 STEP, 10 STOP, 11 CLR.
- o_cmd_ready  out  1  command accepted when valid & ready.
- i_halt_wb  in  1  HALT instruction is in writeback this cycle.
- i_pc  in  NBITS  current PC.
- i_bp_en  in  1  breakpoint enable.
- i_bp_addr  in  NBITS  breakpoint address.
- o_step  out  1  pipeline/PC advance enable.
- o_cpu_reset  out  1  synchronous soft reset to the core.
- o_step_done  out  1  one-cycle pulse when a single STEP completes.
- o_halted  out  1  program finished (DONE state).
- o_bp_hit  out  1  one-cycle pulse when a breakpoint paused RUN.
- o_state  out  3  current state encoding, for debug readout.
- o_cycle_count  out  CNT_BITS  number of cycles with o_step=1.

Behaviour:
- States and encodings: IDLE=0, RUN=1, STEP=2, DONE=3, SRST=4. Other encodings return to IDLE.
- Reset (i_reset=0, async) values: state=IDLE, o_cycle_count=0, rst counter=0. All pulse, flag and enable outputs are 0.
- o_cmd_ready = 1 in IDLE, RUN, DONE; 0 in STEP and SRST.
- Command handling: a command is taken only when i_cmd_valid & o_cmd_ready. Commands not listed for a state are accepted and dropped.
- bp_hit (combinational) = i_bp_en & (i_pc == i_bp_addr).
- o_step (combinational):
  - RUN: 1 when !bp_hit | i_halt_wb.
  - STEP: 1.
  - All other states: 0.
  - Effect: the instruction at the breakpoint is not advanced past in RUN.
- IDLE:
  - RUN -> RUN.
  - STEP -> STEP.
  - CLR -> SRST.
  - STOP dropped.
- RUN transitions, highest priority first:
  - accepted CLR -> SRST.
  - i_halt_wb -> DONE; the halt cycle itself is stepped.
  - accepted STOP -> IDLE.
  - bp_hit -> IDLE, with o_bp_hit pulsed the next cycle.
  - RUN and STEP commands dropped.
- STEP:
  - Exactly one cycle with o_step=1; breakpoint ignored, so a STEP always moves past a breakpoint.
  - Next state DONE if i_halt_wb, else IDLE.
  - o_step_done=1 for one cycle after STEP exits, to IDLE or DONE.
- Resume after breakpoint: RUN issued while still on the breakpoint PC re-pauses immediately with zero steps. The debug unit must STEP first.
- DONE: o_halted=1. CLR -> SRST; all else dropped.
- SRST:
  - o_cpu_reset=1 for exactly RST_CYCLES cycles; o_step=0.
  - o_cycle_count cleared on entry.
  - Then -> IDLE with o_halted=0.
  - Async reset mid-SRST aborts to IDLE.
- o_cycle_count: +1 on every clock edge where o_step=1. Saturates at all-ones with no wrap.
- o_bp_hit, o_step_done, o_halted and o_cpu_reset are registered. o_step is combinational from registered state plus inputs.

Decomposition:
- Shared package (mips_dbg_pkg):
  - command codes CMD_RUN/STEP/STOP/CLR;
  - state encodings;
  - default RST_CYCLES.
- Debug unit and this block both import it.
- One natural sub-module: sat_counter (parameterised width, enable, sync clear, saturate), used for o_cycle_count. The soft-reset counter stays inline.

Test Plan:
- Reset release, then STEP x3 -> exactly 3 single-cycle o_step pulses; o_step_done x3; o_cycle_count=3; state returns to IDLE (0) each time.
- RUN, with i_halt_wb asserted 10 cycles later -> o_step high 11 cycles; state=DONE(3); o_halted=1; o_cycle_count=11; a further RUN is accepted and ignored.
- i_bp_en=1, i_bp_addr=0x10; RUN with PC advancing by 4 -> o_step=0 when i_pc=0x10; o_bp_hit pulse; IDLE; o_cycle_count=4. Then STEP -> one step past 0x10; RUN resumes.
- In RUN, CLR and i_halt_wb in the same cycle -> SRST wins: o_cpu_reset high for 4 cycles; o_cycle_count=0; IDLE; o_halted=0.
- Async reset asserted in the middle of RUN and in the middle of SRST -> immediately state=0, o_step=0, o_cpu_reset=0, counter=0.
- Counter saturation with CNT_BITS=4: RUN for 20 cycles -> o_cycle_count holds at 15.
